mor1kx_icache_refill: RTL and testbench

Instruction-cache refill engine that sits directly upstream of the icache refill write port. On a cache miss it issues one Wishbone B3 wrapping burst read for the missed line. It streams each returned word into the icache as a write (address, data, write-enable). It reports bus errors so the icache can abandon the refill.

---
 rtl/mor1kx_icache_refill_pkg.sv | 37 +++
 rtl/mor1kx_icache_refill.sv | 195 +++++++++++++++++++
 tb/tb_mor1kx_icache_refill.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mor1kx_icache_refill_pkg.sv
// Shared constants for the icache refill engine.
//   - Wishbone B3 cycle-type (CTI) and burst-type (BTE) codes
//   - refill FSM state encodings
//   - helper mapping the line-size exponent to its static wrap burst type
package mor1kx_icache_refill_pkg;

    // Wishbone B3 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone B3 burst type extensions
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;

    // Refill FSM states
    localparam int unsigned ST_W       = 2;
    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_BURST = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

    // A 16 B line wraps over 4 beats, a 32 B line over 8 beats.
    // Any other size falls back to a linear burst.
    function automatic logic [1:0] bte_for_block_width(input int unsigned bw);
        logic [1:0] bte;
        if (bw == 32'd4) begin
            bte = BTE_WRAP4;
        end else if (bw == 32'd5) begin
            bte = BTE_WRAP8;
        end else begin
            bte = BTE_LINEAR;
        end
        return bte;
    endfunction

endpackage

// File: rtl/mor1kx_icache_refill.sv
// Instruction-cache refill engine.
// On a miss it issues one Wishbone B3 wrapping burst for the missed line and
// streams every returned word straight into the icache refill write port.
// Bus errors are reported as a one-cycle pulse so the icache can abandon
// the refill; an icache abort (refill_i falling) terminates the burst.
//
// Optional feature: define MOR1KX_ICACHE_REFILL_CWF_EN for critical-word-first
// ordering (burst starts at the missed word and wraps); otherwise the burst
// starts at the line base.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   refill_req_i        icache miss request
//   refill_i            icache is in its REFILL state
//   refill_adr_i        missed fetch address
//   wradr_o/wrdat_o     icache write address / data (follow the bus beat)
//   we_o                icache write strobe, combinational on the beat ack
//   refill_err_o        one-cycle pulse after a bus error
//   busy_o              engine not IDLE
//   wbm_*               Wishbone B3 master (read-only bursts)
module mor1kx_icache_refill
    import mor1kx_icache_refill_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH      = 32,
    parameter int unsigned OPTION_ICACHE_BLOCK_WIDTH = 5
) (
    input  logic                            clk,
    input  logic                            rst_n,

    input  logic                            refill_req_i,
    input  logic                            refill_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,

    output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
    output logic                            we_o,
    output logic                            refill_err_o,
    output logic                            busy_o,

    output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
    output logic                            wbm_cyc_o,
    output logic                            wbm_stb_o,
    output logic                            wbm_we_o,
    output logic [3:0]                      wbm_sel_o,
    output logic [2:0]                      wbm_cti_o,
    output logic [1:0]                      wbm_bte_o,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
    input  logic                            wbm_ack_i,
    input  logic                            wbm_err_i
);

    localparam int unsigned AW     = OPTION_OPERAND_WIDTH;
    localparam int unsigned BW     = OPTION_ICACHE_BLOCK_WIDTH;
    localparam int unsigned OFF_W  = BW - 2;
    localparam int unsigned BASE_W = AW - BW;
    localparam int unsigned BEATS  = 1 << OFF_W;

    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(BEATS - 1);
    localparam logic [1:0]       BTE      = bte_for_block_width(BW);

    logic [ST_W-1:0]   r_state;
    logic [ST_W-1:0]   w_state_nxt;
    logic [BASE_W-1:0] r_base;
    logic [BASE_W-1:0] w_base_nxt;
    logic [OFF_W-1:0]  r_off;
    logic [OFF_W-1:0]  w_off_nxt;
    logic [OFF_W-1:0]  r_cnt;
    logic [OFF_W-1:0]  w_cnt_nxt;
    logic              r_cyc;
    logic              w_cyc_nxt;
    logic [2:0]        r_cti;
    logic [2:0]        w_cti_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_busy;
    logic [OFF_W-1:0]  w_start_off;
    logic              w_beat_write;

    // Word offset the burst starts from.
`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
    logic w_unused_adr;
    assign w_start_off  = refill_adr_i[BW-1:2];
    assign w_unused_adr = ^refill_adr_i[1:0];
`else
    logic w_unused_adr;
    assign w_start_off  = '0;
    assign w_unused_adr = ^refill_adr_i[BW-1:0];
`endif

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_base_nxt  = r_base;
        w_off_nxt   = r_off;
        w_cnt_nxt   = r_cnt;
        w_cyc_nxt   = r_cyc;
        w_cti_nxt   = r_cti;
        w_err_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (refill_req_i && refill_i) begin
                    w_base_nxt  = refill_adr_i[AW-1:BW];
                    w_off_nxt   = w_start_off;
                    w_cnt_nxt   = '0;
                    w_cyc_nxt   = 1'b1;
                    w_cti_nxt   = CTI_INCR;
                    w_state_nxt = ST_BURST;
                end
            end

            ST_BURST: begin
                if (wbm_err_i) begin
                    // Error wins over a simultaneous ack: the beat is dropped.
                    w_err_nxt   = 1'b1;
                    w_cyc_nxt   = 1'b0;
                    w_cti_nxt   = CTI_CLASSIC;
                    w_state_nxt = ST_DONE;
                end else if (!refill_i) begin
                    // icache abandoned the refill.
                    w_cyc_nxt   = 1'b0;
                    w_cti_nxt   = CTI_CLASSIC;
                    w_state_nxt = ST_DONE;
                end else if (wbm_ack_i) begin
                    // Offset wraps inside the line through natural overflow.
                    w_off_nxt = r_off + OFF_W'(1);
                    w_cnt_nxt = r_cnt + OFF_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        w_cyc_nxt   = 1'b0;
                        w_cti_nxt   = CTI_CLASSIC;
                        w_state_nxt = ST_DONE;
                    end else if (w_cnt_nxt == CNT_LAST) begin
                        w_cti_nxt = CTI_EOB;
                    end else begin
                        w_cti_nxt = CTI_INCR;
                    end
                end
            end

            ST_DONE: begin
                // One dead cycle so the icache can leave REFILL before a
                // still-asserted request is sampled again.
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_cyc_nxt   = 1'b0;
                w_cti_nxt   = CTI_CLASSIC;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_base  <= '0;
            r_off   <= '0;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_cti   <= CTI_CLASSIC;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_base  <= w_base_nxt;
            r_off   <= w_off_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cyc   <= w_cyc_nxt;
            r_cti   <= w_cti_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // A beat is written only on a clean ack while the icache still wants it.
    assign w_beat_write = (r_state == ST_BURST) && wbm_ack_i && !wbm_err_i &&
                          refill_i && rst_n;

    assign wbm_adr_o    = {r_base, r_off, 2'b00};
    assign wbm_cyc_o    = r_cyc;
    assign wbm_stb_o    = r_cyc;
    assign wbm_we_o     = 1'b0;
    assign wbm_sel_o    = 4'hf;
    assign wbm_cti_o    = r_cti;
    assign wbm_bte_o    = BTE;

    assign we_o         = w_beat_write;
    assign wradr_o      = wbm_adr_o;
    assign wrdat_o      = wbm_dat_i;
    assign refill_err_o = r_err;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_mor1kx_icache_refill.sv
// Self-checking bench for mor1kx_icache_refill: an 8-beat (BW=5) and a 4-beat
// (BW=4) instance share stimulus; sel chooses which one a burst targets.
module tb_mor1kx_icache_refill;

`ifdef MOR1KX_ICACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        req;
    logic        refill;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        ack;
    logic        err;

    logic [31:0] wradr8, wrdat8, badr8, wradr4, wrdat4, badr4;
    logic        we8, rerr8, busy8, cyc8, stb8, bwe8;
    logic        we4, rerr4, busy4, cyc4, stb4, bwe4;
    logic [3:0]  bsel8, bsel4;
    logic [2:0]  cti8, cti4;
    logic [1:0]  bte8, bte4;

    logic [31:0] o_wradr, o_wrdat, o_adr;
    logic        o_we, o_rerr, o_busy, o_cyc, o_stb, o_bwe;
    logic [3:0]  o_bsel;
    logic [2:0]  o_cti;
    logic [1:0]  o_bte;

    int n_checks = 0;
    int n_err    = 0;
    int we_count = 0;

    always #5 clk = ~clk;

    mor1kx_icache_refill #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(5)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .refill_req_i(req & ~sel), .refill_i(refill), .refill_adr_i(adr),
        .wradr_o(wradr8), .wrdat_o(wrdat8), .we_o(we8), .refill_err_o(rerr8), .busy_o(busy8),
        .wbm_adr_o(badr8), .wbm_cyc_o(cyc8), .wbm_stb_o(stb8), .wbm_we_o(bwe8),
        .wbm_sel_o(bsel8), .wbm_cti_o(cti8), .wbm_bte_o(bte8),
        .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(err));

    mor1kx_icache_refill #(.OPTION_OPERAND_WIDTH(32), .OPTION_ICACHE_BLOCK_WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .refill_req_i(req & sel), .refill_i(refill), .refill_adr_i(adr),
        .wradr_o(wradr4), .wrdat_o(wrdat4), .we_o(we4), .refill_err_o(rerr4), .busy_o(busy4),
        .wbm_adr_o(badr4), .wbm_cyc_o(cyc4), .wbm_stb_o(stb4), .wbm_we_o(bwe4),
        .wbm_sel_o(bsel4), .wbm_cti_o(cti4), .wbm_bte_o(bte4),
        .wbm_dat_i(dat), .wbm_ack_i(ack), .wbm_err_i(err));

    always_comb begin
        o_wradr = sel ? wradr4 : wradr8;
        o_wrdat = sel ? wrdat4 : wrdat8;
        o_we    = sel ? we4    : we8;
        o_rerr  = sel ? rerr4  : rerr8;
        o_busy  = sel ? busy4  : busy8;
        o_adr   = sel ? badr4  : badr8;
        o_cyc   = sel ? cyc4   : cyc8;
        o_stb   = sel ? stb4   : stb8;
        o_bwe   = sel ? bwe4   : bwe8;
        o_bsel  = sel ? bsel4  : bsel8;
        o_cti   = sel ? cti4   : cti8;
        o_bte   = sel ? bte4   : bte8;
    end

    // Count icache writes as the DUT presents them at the clock edge.
    always @(posedge clk) begin
        if (o_we) we_count <= we_count + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: beat k of a refill is the line base plus the k-th word after
    // the start offset, modulo the line size.
    function automatic logic [31:0] exp_adr(input logic s, input logic [31:0] a, input int k);
        logic [31:0] line, base, start;
        line  = s ? 32'd16 : 32'd32;
        base  = a & ~(line - 32'd1);
        start = CWF ? (a & (line - 32'd1) & 32'hFFFF_FFFC) : 32'd0;
        return base | ((start + 32'(4 * k)) % line);
    endfunction

    function automatic logic [31:0] dat_for(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [2:0] exp_cti(input int k, input int beats);
        return (k == beats - 1) ? 3'b111 : 3'b010;
    endfunction

    // Drive one refill starting at a negedge; returns at a negedge with the
    // engine back in IDLE.
    task automatic run_burst(input logic s, input logic [31:0] a, input int waits,
                             input int err_beat, input int abort_beat, input int rst_beat,
                             input logic hold, input logic [31:0] exp_first,
                             input logic [1:0] exp_bte);
        int beats, w, wc0;
        logic [31:0] ea, ed;
        beats = s ? 4 : 8;
        sel   = s;
        #1;
        check("idle_busy", 32'(o_busy), 32'd0);
        check("bte", 32'(o_bte), 32'(exp_bte));
        wc0    = we_count;
        req    = 1'b1;
        refill = 1'b1;
        adr    = a;
        @(posedge clk); @(negedge clk);
        if (!hold) req = 1'b0;
        check("cyc_rise", 32'(o_cyc), 32'd1);
        check("first_adr", o_adr, exp_first);
        for (int k = 0; k < beats; k++) begin
            ea = exp_adr(s, a, k);
            ed = dat_for(ea);
            w  = (waits < 0) ? int'($urandom_range(0, 2)) : waits;
            for (int j = 0; j < w; j++) begin
                ack = 1'b0;
                #1;
                check("wait_adr", o_adr, ea);
                check("wait_cti", 32'(o_cti), 32'(exp_cti(k, beats)));
                check("wait_stb", 32'(o_stb), 32'd1);
                check("wait_we", 32'(o_we), 32'd0);
                @(posedge clk); @(negedge clk);
            end
            check("beat_adr", o_adr, ea);
            check("beat_cti", 32'(o_cti), 32'(exp_cti(k, beats)));
            check("beat_cyc", 32'(o_cyc), 32'd1);
            if (k == rst_beat) begin
                rst_n = 1'b0;
                req   = 1'b0;
                @(posedge clk); @(negedge clk);
                rst_n = 1'b1;
                #1;
                check("rst_cyc", 32'(o_cyc), 32'd0);
                check("rst_stb", 32'(o_stb), 32'd0);
                check("rst_busy", 32'(o_busy), 32'd0);
                check("rst_adr", o_adr, 32'd0);
                check("rst_cti", 32'(o_cti), 32'd0);
                ack = 1'b1;
                dat = ed;
                #1;
                check("rst_we", 32'(o_we), 32'd0);
                @(posedge clk); @(negedge clk);
                ack = 1'b0;
                check("rst_rerr", 32'(o_rerr), 32'd0);
                check("rst_writes", 32'(we_count - wc0), 32'(k));
                return;
            end
            if (k == abort_beat) begin
                refill = 1'b0;
                ack    = 1'b1;
                dat    = ed;
                #1;
                check("abort_we", 32'(o_we), 32'd0);
                @(posedge clk); @(negedge clk);
                ack = 1'b0;
                check("abort_cyc", 32'(o_cyc), 32'd0);
                check("abort_done_busy", 32'(o_busy), 32'd1);
                @(posedge clk); @(negedge clk);
                check("abort_idle", 32'(o_busy), 32'd0);
                check("abort_writes", 32'(we_count - wc0), 32'(k));
                refill = 1'b1;
                return;
            end
            dat = ed;
            ack = 1'b1;
            if (k == err_beat) begin
                err = 1'b1;
                #1;
                check("err_we", 32'(o_we), 32'd0);
                @(posedge clk); @(negedge clk);
                ack = 1'b0;
                err = 1'b0;
                check("err_pulse", 32'(o_rerr), 32'd1);
                check("err_cyc", 32'(o_cyc), 32'd0);
                check("err_done_busy", 32'(o_busy), 32'd1);
                @(posedge clk); @(negedge clk);
                check("err_pulse_end", 32'(o_rerr), 32'd0);
                check("err_idle", 32'(o_busy), 32'd0);
                check("err_writes", 32'(we_count - wc0), 32'(k));
                return;
            end
            #1;
            check("we", 32'(o_we), 32'd1);
            check("wradr", o_wradr, ea);
            check("wrdat", o_wrdat, ed);
            @(posedge clk); @(negedge clk);
            ack = 1'b0;
        end
        #1;
        check("end_cyc", 32'(o_cyc), 32'd0);
        check("done_busy", 32'(o_busy), 32'd1);
        check("end_rerr", 32'(o_rerr), 32'd0);
        @(posedge clk); @(negedge clk);
        // A request still held through DONE must not have restarted a burst.
        check("idle_after_done", 32'(o_busy), 32'd0);
        check("idle_cyc", 32'(o_cyc), 32'd0);
        check("writes", 32'(we_count - wc0), 32'(beats));
    endtask

    typedef struct {
        logic        s;
        logic [31:0] a;
        int          waits;
        int          err_beat;
        int          abort_beat;
        int          rst_beat;
        logic        hold;
        logic [31:0] exp_first;
        logic [1:0]  exp_bte;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 32'h0000_1014, 0, -1, -1, -1, 1'b0, CWF ? 32'h1014 : 32'h1000, 2'b10};
        vecs[1] = '{1'b0, 32'h0000_1014, 0, -1, -1, -1, 1'b1, CWF ? 32'h1014 : 32'h1000, 2'b10};
        vecs[2] = '{1'b0, 32'h0000_2048, 1, -1, -1, -1, 1'b0, CWF ? 32'h2048 : 32'h2040, 2'b10};
        vecs[3] = '{1'b1, 32'h0000_2008, 2, -1, -1, -1, 1'b0, CWF ? 32'h2008 : 32'h2000, 2'b01};
        vecs[4] = '{1'b0, 32'h0000_1014, 0,  2, -1, -1, 1'b0, CWF ? 32'h1014 : 32'h1000, 2'b10};
        vecs[5] = '{1'b0, 32'h0000_3000, 1, -1, -1, -1, 1'b0, 32'h3000, 2'b10};
        vecs[6] = '{1'b0, 32'h0000_101C, 0, -1, -1,  4, 1'b0, CWF ? 32'h101C : 32'h1000, 2'b10};
        vecs[7] = '{1'b1, 32'h0000_200C, 1, -1,  1, -1, 1'b0, CWF ? 32'h200C : 32'h2000, 2'b01};
        vecs[8] = '{1'b0, 32'h8000_4FFC, -1, -1, -1, -1, 1'b0, CWF ? 32'h8000_4FFC : 32'h8000_4FE0, 2'b10};

        rst_n = 1'b0; sel = 1'b0; req = 1'b0; refill = 1'b0;
        adr = 32'd0; dat = 32'd0; ack = 1'b0; err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc8", 32'(cyc8), 32'd0);
        check("rst_stb8", 32'(stb8), 32'd0);
        check("rst_we8", 32'(we8), 32'd0);
        check("rst_rerr8", 32'(rerr8), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_adr8", badr8, 32'd0);
        check("rst_wradr8", wradr8, 32'd0);
        check("rst_cti8", 32'(cti8), 32'd0);
        check("bte8", 32'(bte8), 32'd2);
        check("bte4", 32'(bte4), 32'd1);
        check("bus_we", 32'(bwe8), 32'd0);
        check("bus_sel", 32'(bsel8), 32'hf);
        check("rst_cyc4", 32'(cyc4), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_burst(vecs[i].s, vecs[i].a, vecs[i].waits, vecs[i].err_beat,
                      vecs[i].abort_beat, vecs[i].rst_beat, vecs[i].hold,
                      vecs[i].exp_first, vecs[i].exp_bte);
        end

        for (int i = 0; i < 24; i++) begin
            logic        s;
            logic [31:0] a;
            int          eb;
            s  = 1'($urandom_range(0, 1));
            a  = $urandom;
            eb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, s ? 3 : 7)) : -1;
            run_burst(s, a, -1, eb, -1, -1, 1'b0, exp_adr(s, a, 0), s ? 2'b01 : 2'b10);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
